// File: rtl/main_memory_if.sv
// Core-to-memory bus: combinational read port plus a strobed store port.
// The memory attaches to master, the core datapath to slave.
interface mem_if;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic [31:0] rd_data;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;
    logic        wr_enable;

    modport master (
        input  rd_addr, rd_size,
        input  wr_addr, wr_size, wr_data, wr_enable,
        output rd_data
    );

    modport slave (
        output rd_addr, rd_size,
        output wr_addr, wr_size, wr_data, wr_enable,
        input  rd_data
    );
endinterface

// File: rtl/main_memory.sv
// Word-organised RAM with post-reset clear sweep and tohost mailbox.
// Optional MEM_MISALIGN_CHECK_EN adds a sticky misalign_o flag.
module main_memory #(
    parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
    parameter int          SIZE_WORDS     = 16384,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    mem_if.master       memif,
    output logic        init_done_o,
    output logic [31:0] tohost_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        tohost_valid_o
);
    localparam int AW = $clog2(SIZE_WORDS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state;
    logic [AW-1:0] clr_idx;
    logic [31:0]   ram [SIZE_WORDS];

    logic [31:0] rd_off, wr_off, rd_word;
    logic        rd_hit, wr_hit, rd_box, wr_box;
    logic        wr_bad, wr_go;
    logic [3:0]  wr_mask;
    logic [31:0] wr_lanes;

    function automatic logic misal(input logic [1:0] sz,
                                   input logic [1:0] lo);
        return (sz == 2'd1 && lo[0]) || (sz[1] && lo != 2'd0);
    endfunction

    // Offsets are checked for both underflow and overflow so a wrapped
    // subtraction never aliases back into the array.
    assign rd_off  = memif.rd_addr - BASE_ADDR;
    assign wr_off  = memif.wr_addr - BASE_ADDR;
    assign rd_hit  = (memif.rd_addr >= BASE_ADDR) &&
                     (rd_off[31:AW+2] == '0);
    assign wr_hit  = (memif.wr_addr >= BASE_ADDR) &&
                     (wr_off[31:AW+2] == '0);
    assign rd_box  = memif.rd_addr[31:2] == TOHOST_ADDR[31:2];
    assign wr_box  = memif.wr_addr[31:2] == TOHOST_ADDR[31:2];
    assign rd_word = ram[rd_off[AW+1:2]];

`ifdef MEM_MISALIGN_CHECK_EN
    assign wr_bad = misal(memif.wr_size, wr_off[1:0]);
`else
    assign wr_bad = 1'b0;
`endif

    assign wr_go = reset_ni && state == RUN &&
                   memif.wr_enable && !wr_bad;

    // Sized read mux: right-justified, zero-extended, zero when idle.
    always_comb begin
        memif.rd_data = '0;
        if (state == RUN) begin
            if (rd_box) begin
                memif.rd_data = tohost_o;
            end else if (rd_hit) begin
                case (memif.rd_size)
                    2'd0: memif.rd_data =
                        {24'b0, rd_word[8*rd_off[1:0] +: 8]};
                    2'd1: memif.rd_data =
                        {16'b0, rd_word[16*rd_off[1] +: 16]};
                    default: memif.rd_data = rd_word;
                endcase
            end
        end
    end

    // Byte-lane enables and replicated write data by size.
    always_comb begin
        wr_mask  = 4'b1111;
        wr_lanes = memif.wr_data;
        case (memif.wr_size)
            2'd0: begin
                wr_mask  = 4'b0001 << wr_off[1:0];
                wr_lanes = {4{memif.wr_data[7:0]}};
            end
            2'd1: begin
                wr_mask  = wr_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{memif.wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM update: clear sweep, else masked store; untouched by reset.
    always_ff @(posedge clk_i) begin
        if (reset_ni && state == CLEAR) begin
            ram[clr_idx] <= '0;
        end else if (wr_go && wr_hit && !wr_box) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b])
                    ram[wr_off[AW+1:2]][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // Clear/run sequencer with registered done flag and mailbox.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state          <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_idx        <= '0;
            init_done_o    <= !CLEAR_ON_RESET;
            tohost_o       <= '0;
            tohost_valid_o <= 1'b0;
        end else begin
            tohost_valid_o <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(SIZE_WORDS - 1)) begin
                        state       <= RUN;
                        init_done_o <= 1'b1;
                    end
                end
                default: begin
                    if (wr_go && wr_box) begin
                        tohost_o       <= memif.wr_data;
                        tohost_valid_o <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // Sticky misalignment flag over both ports while running.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            misalign_o <= 1'b0;
        end else if (state == RUN) begin
            if (misal(memif.rd_size, rd_off[1:0]) ||
                (memif.wr_enable && wr_bad))
                misalign_o <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory with SIZE_WORDS=16.
// Expected values go through a scoreboard queue.
module tb_main_memory;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic [31:0] tohost;
    logic        tohost_valid;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    mem_if bus ();

    main_memory #(
        .BASE_ADDR     (BASE),
        .SIZE_WORDS    (16),
        .TOHOST_ADDR   (TOHOST),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .memif         (bus),
        .init_done_o   (init_done),
        .tohost_o      (tohost),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o    (misalign),
`endif
        .tohost_valid_o(tohost_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] e, input string tag);
        @(negedge clk);
        bus.rd_addr = a;
        bus.rd_size = s;
        exp_q.push_back(e);
        #1;
        chk(tag, bus.rd_data);
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] d);
        @(negedge clk);
        bus.wr_addr   = a;
        bus.wr_size   = s;
        bus.wr_data   = d;
        bus.wr_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_enable = 1'b0;
    endtask

    task automatic wait_init(output int n, output logic seen);
        n    = 0;
        seen = 1'b0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (tohost_valid) seen = 1'b1;
        end while (!init_done && n < 100);
    endtask

    initial begin
        int   n;
        logic seen;
        rst_n         = 1'b0;
        bus.rd_addr   = BASE;
        bus.rd_size   = 2'd2;
        bus.wr_addr   = BASE;
        bus.wr_size   = 2'd2;
        bus.wr_data   = '0;
        bus.wr_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(32'h0); chk("rst_init_done", {31'b0, init_done});
        exp_q.push_back(32'h0); chk("rst_tohost", tohost);
        exp_q.push_back(32'h0); chk("rst_valid", {31'b0, tohost_valid});

        // Release reset with stores held active through the sweep.
        @(negedge clk);
        rst_n         = 1'b1;
        bus.wr_addr   = BASE + 32'h8;
        bus.wr_size   = 2'd2;
        bus.wr_data   = 32'hFFFF_FFFF;
        bus.wr_enable = 1'b1;
        #1;
        exp_q.push_back(32'h0); chk("clear_rd_zero", bus.rd_data);
        wait_init(n, seen);
        bus.wr_enable = 1'b0;
        exp_q.push_back(32'd16); chk("clear_latency", n);
        exp_q.push_back(32'h0);  chk("clear_no_pulse", {31'b0, seen});

        @(negedge clk);
        bus.wr_addr   = TOHOST;
        bus.wr_data   = 32'h77;
        bus.wr_enable = 1'b1;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        bus.wr_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_enable = 1'b1;
        #1;
        wait_init(n, seen);
        bus.wr_enable = 1'b0;
        exp_q.push_back(32'd16); chk("clear2_latency", n);
        exp_q.push_back(32'h0);  chk("clear_mbox_drop", tohost);

        for (int i = 0; i < 16; i++)
            rd(BASE + 32'(4 * i), 2'd2, 32'h0, "swept_zero");

        wr(BASE + 32'h4, 2'd2, 32'hDEAD_BEEF);
        rd(BASE + 32'h5, 2'd0, 32'h0000_00BE, "byte_rd");
        rd(BASE + 32'h6, 2'd1, 32'h0000_DEAD, "half_rd");
        rd(BASE + 32'h4, 2'd3, 32'hDEAD_BEEF, "rsvd_size_rd");

        wr(BASE + 32'h4, 2'd2, 32'h1122_3344);
        wr(BASE + 32'h7, 2'd0, 32'hFFFF_FF5A);
        rd(BASE + 32'h4, 2'd2, 32'h5A22_3344, "byte_merge");

        // Same-cycle read and write of one word.
        @(negedge clk);
        bus.rd_addr   = BASE + 32'h8;
        bus.rd_size   = 2'd2;
        bus.wr_addr   = BASE + 32'h8;
        bus.wr_size   = 2'd2;
        bus.wr_data   = 32'h1;
        bus.wr_enable = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        chk("rw_old", bus.rd_data);
        @(posedge clk);
        #1;
        bus.wr_enable = 1'b0;
        exp_q.push_back(32'h1);
        chk("rw_new", bus.rd_data);

        wr(TOHOST, 2'd2, 32'h1);
        exp_q.push_back(32'h1); chk("mbox_data", tohost);
        exp_q.push_back(32'h1); chk("mbox_pulse", {31'b0, tohost_valid});
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0); chk("mbox_pulse_end", {31'b0, tohost_valid});
        rd(TOHOST, 2'd2, 32'h1, "mbox_rd");

        @(negedge clk);
        bus.wr_addr   = TOHOST;
        bus.wr_size   = 2'd0;
        bus.wr_data   = 32'hA5A5_0002;
        bus.wr_enable = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h1); chk("b2b_pulse1", {31'b0, tohost_valid});
        bus.wr_data = 32'h3;
        @(posedge clk);
        #1;
        bus.wr_enable = 1'b0;
        exp_q.push_back(32'h1); chk("b2b_pulse2", {31'b0, tohost_valid});
        exp_q.push_back(32'h3); chk("b2b_data", tohost);
        rd(BASE + 32'h8, 2'd2, 32'h1, "mbox_no_ram");

        rd(32'h0000_FFFC, 2'd2, 32'h0, "below_base");
        wr(BASE + 32'h40, 2'd2, 32'hCAFE_F00D);
        rd(BASE + 32'h40, 2'd2, 32'h0, "above_top_rd");
        rd(BASE, 2'd2, 32'h0, "no_alias");

        wr(BASE + 32'h2, 2'd1, 32'h1234_ABCD);
        rd(BASE, 2'd2, 32'hABCD_0000, "half_wr_hi");

`ifdef MEM_MISALIGN_CHECK_EN
        exp_q.push_back(32'h0); chk("misalign_clear", {31'b0, misalign});
        wr(BASE + 32'h1, 2'd1, 32'h0000_BEEF);
        exp_q.push_back(32'h1); chk("misalign_set", {31'b0, misalign});
        rd(BASE, 2'd2, 32'hABCD_0000, "misalign_drop");
`else
        wr(BASE + 32'h1, 2'd1, 32'h0000_BEEF);
        rd(BASE, 2'd2, 32'hABCD_BEEF, "misalign_mask");
`endif

        // Reset in the middle of the sweep restarts it.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        exp_q.push_back(32'h0); chk("mid_clear_busy", {31'b0, init_done});
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0); chk("mid_rst_done", {31'b0, init_done});
        exp_q.push_back(32'h0); chk("mid_rst_tohost", tohost);
`ifdef MEM_MISALIGN_CHECK_EN
        exp_q.push_back(32'h0); chk("misalign_rst", {31'b0, misalign});
`endif
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n, seen);
        exp_q.push_back(32'd16); chk("restart_latency", n);
        rd(BASE + 32'h4, 2'd2, 32'h0, "restart_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
